// File: rtl/pi_ctrl_pkg.sv
// Shared FSM state encoding, default widths and a signed clamp helper for the PI controller.
// Purely combinational definitions; no latency or backpressure of its own.
package pi_ctrl_pkg;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_SAT, S_UPD} state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_COEF_W = 16;
   localparam int DEF_ACC_W  = 40;

   // Wide enough for every intermediate the controller clamps.
   localparam int CLAMP_W = 128;

   function automatic logic signed [CLAMP_W-1:0] sclamp(
      input logic signed [CLAMP_W-1:0] val,
      input logic signed [CLAMP_W-1:0] lo,
      input logic signed [CLAMP_W-1:0] hi
   );
      if (val > hi) return hi;
      if (val < lo) return lo;
      return val;
   endfunction

endpackage

// File: rtl/sat_clamp.sv
// Signed saturating narrowing from IN_W to OUT_W bits within [MIN, MAX].
// Combinational, zero latency; no flow control.
module sat_clamp
   import pi_ctrl_pkg::*;
#(
   parameter int                      IN_W  = 48,
   parameter int                      OUT_W = 32,
   parameter logic signed [OUT_W-1:0] MIN   = {1'b1, {(OUT_W-1){1'b0}}},
   parameter logic signed [OUT_W-1:0] MAX   = {1'b0, {(OUT_W-1){1'b1}}}
) (
   input  logic signed [IN_W-1:0]  in_dat,
   output logic signed [OUT_W-1:0] out_dat
);

   logic signed [CLAMP_W-1:0] res;

   always_comb begin
      res     = sclamp(CLAMP_W'(in_dat), CLAMP_W'(MIN), CLAMP_W'(MAX));
      out_dat = OUT_W'(res);
   end

endmodule

// File: rtl/pi_sat_ctrl.sv
// Pipelined saturating PI controller with back-calculation anti-windup; PI_SAT_PRELOAD_EN adds integrator preload.
// Latency: i_valid in cycle N -> o_valid in N+3; samples arriving while o_busy is high are dropped.
module pi_sat_ctrl
   import pi_ctrl_pkg::*;
#(
   parameter int                       DATA_W    = DEF_DATA_W,
   parameter int                       COEF_W    = DEF_COEF_W,
   parameter int                       ACC_W     = DEF_ACC_W,
   parameter logic signed [COEF_W-1:0] Kp        = COEF_W'(1),
   parameter logic signed [COEF_W-1:0] TsKi      = COEF_W'(0),
   parameter logic signed [COEF_W-1:0] Kaw       = COEF_W'(0),
   parameter int                       shift_Kp  = 0,
   parameter int                       shift_Ki  = 0,
   parameter int                       shift_Kaw = 0,
   parameter logic signed [DATA_W-1:0] OUT_MAX   = {1'b0, {(DATA_W-1){1'b1}}},
   parameter logic signed [DATA_W-1:0] OUT_MIN   = {1'b1, {(DATA_W-1){1'b0}}}
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic                     i_valid,
   input  logic signed [DATA_W-1:0] i_err,
   input  logic                     i_hold,
   input  logic                     i_clear,
`ifdef PI_SAT_PRELOAD_EN
   input  logic                     i_preload,
   input  logic signed [ACC_W-1:0]  i_preload_val,
`endif
   output logic signed [DATA_W-1:0] o_PI,
   output logic                     o_valid,
   output logic                     o_busy,
   output logic                     o_sat
);

   localparam int P_W   = DATA_W + COEF_W;
   localparam int SUM_W = ACC_W + 2;
   localparam int I_W   = ACC_W + COEF_W;
   localparam int U_W   = I_W + 1;
   localparam int D_W   = U_W + 1;
   localparam int AW_W  = D_W + COEF_W;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t                   state, state_nxt;
   logic signed [DATA_W-1:0] e_r;
   logic signed [P_W-1:0]    p_r, p_nxt, p_sh;
   logic signed [ACC_W-1:0]  acc, aw_term, acc_tmp_r, acc_tmp_nxt, acc_sum_c, aw_c;
   logic signed [SUM_W-1:0]  acc_sum;
   logic signed [I_W-1:0]    i_prod, i_sh;
   logic signed [U_W-1:0]    u_unsat, u_unsat_r;
   logic signed [DATA_W-1:0] u_c;
   logic                     sat_c;
   logic signed [D_W-1:0]    u_diff;
   logic signed [AW_W-1:0]   aw_prod, aw_sh;

   always_comb begin
      state_nxt = state;
      o_busy    = 1'b1;
      o_valid   = 1'b0;
      case (state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_valid) state_nxt = S_MUL;
         end
         S_MUL:   state_nxt = S_SAT;
         S_SAT:   state_nxt = S_UPD;
         S_UPD: begin
            o_valid   = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Every sum is widened before clamping so nothing can wrap.
   always_comb begin
      p_nxt       = P_W'(Kp) * P_W'(e_r);
      acc_sum     = SUM_W'(acc) + SUM_W'(e_r) - SUM_W'(aw_term);
      acc_tmp_nxt = i_hold ? acc : acc_sum_c;
      i_prod      = I_W'(TsKi) * I_W'(acc_tmp_r);
      p_sh        = p_r >>> shift_Kp;
      i_sh        = i_prod >>> shift_Ki;
      u_unsat     = U_W'(p_sh) + U_W'(i_sh);
      sat_c       = (U_W'(u_c) != u_unsat);
      u_diff      = D_W'(u_unsat_r) - D_W'(o_PI);
      aw_prod     = AW_W'(Kaw) * AW_W'(u_diff);
      aw_sh       = aw_prod >>> shift_Kaw;
   end

   sat_clamp #(.IN_W(SUM_W), .OUT_W(ACC_W), .MIN(ACC_MIN), .MAX(ACC_MAX))
      u_acc_clamp (.in_dat(acc_sum), .out_dat(acc_sum_c));

   sat_clamp #(.IN_W(U_W), .OUT_W(DATA_W), .MIN(OUT_MIN), .MAX(OUT_MAX))
      u_out_clamp (.in_dat(u_unsat), .out_dat(u_c));

   sat_clamp #(.IN_W(AW_W), .OUT_W(ACC_W), .MIN(ACC_MIN), .MAX(ACC_MAX))
      u_aw_clamp (.in_dat(aw_sh), .out_dat(aw_c));

   // Outputs register at the end of S_SAT so o_PI is already valid while o_valid pulses in S_UPD.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state     <= S_IDLE;
         e_r       <= '0;
         p_r       <= '0;
         acc_tmp_r <= '0;
         u_unsat_r <= '0;
         acc       <= '0;
         aw_term   <= '0;
         o_PI      <= '0;
         o_sat     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && i_valid) e_r <= i_err;
         if (state == S_MUL) begin
            p_r       <= p_nxt;
            acc_tmp_r <= acc_tmp_nxt;
         end
         if (state == S_SAT) begin
            u_unsat_r <= u_unsat;
            o_PI      <= u_c;
            o_sat     <= sat_c;
         end
         if (i_clear) begin
            acc     <= '0;
            aw_term <= '0;
         end
`ifdef PI_SAT_PRELOAD_EN
         else if (i_preload) begin
            acc     <= i_preload_val;
            aw_term <= '0;
         end
`endif
         else if (state == S_UPD) begin
            acc     <= acc_tmp_r;
            aw_term <= o_sat ? aw_c : '0;
         end
      end
   end

endmodule

// File: tb/tb_pi_sat_ctrl.sv
// Randomised scoreboard bench for pi_sat_ctrl against an arithmetic reference model.
module tb_pi_sat_ctrl;

   localparam int DATA_W = 32;
   localparam int COEF_W = 16;
   localparam int ACC_W  = 40;
   localparam longint KP = 1, KI = 1, KAW = 1;
   localparam longint U_MAX = 1000, U_MIN = -1000;
   localparam longint A_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
   localparam longint A_MIN = -(longint'(1) <<< (ACC_W-1));

   logic                     i_CLK = 1'b0;
   logic                     i_RST = 1'b1;
   logic                     i_valid = 1'b0;
   logic                     i_hold = 1'b0;
   logic                     i_clear = 1'b0;
   logic signed [DATA_W-1:0] i_err = '0;
   logic signed [DATA_W-1:0] o_PI;
   logic                     o_valid, o_busy, o_sat;

   pi_sat_ctrl #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W),
      .Kp(16'sd1), .TsKi(16'sd1), .Kaw(16'sd1),
      .shift_Kp(0), .shift_Ki(0), .shift_Kaw(0),
      .OUT_MAX(32'sd1000), .OUT_MIN(-32'sd1000)
   ) dut (
      .i_CLK(i_CLK), .i_RST(i_RST), .i_valid(i_valid), .i_err(i_err),
      .i_hold(i_hold), .i_clear(i_clear),
      .o_PI(o_PI), .o_valid(o_valid), .o_busy(o_busy), .o_sat(o_sat)
   );

   always #5 i_CLK = ~i_CLK;

   int cyc = 0;
   always @(posedge i_CLK) cyc <= cyc + 1;

   typedef struct { longint u; bit sat; int cyc; } exp_t;
   exp_t sb[$];

   int     n_cmp = 0, n_fail = 0, n_vld = 0, free_cyc = 0;
   longint m_acc = 0, m_aw = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint clip(input longint v, input longint lo, input longint hi);
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   // Controller behaviour as plain arithmetic on one accepted sample.
   function automatic void model(input longint e, input bit hold, output longint u, output bit sat);
      longint at, uu;
      at  = hold ? m_acc : clip(m_acc + e - m_aw, A_MIN, A_MAX);
      uu  = KP * e + KI * at;
      u   = clip(uu, U_MIN, U_MAX);
      sat = (u != uu);
      m_acc = at;
      m_aw  = clip(KAW * (uu - u), A_MIN, A_MAX);
   endfunction

   function automatic longint rnd_err();
      if ($urandom_range(0, 9) == 0) return longint'($signed($urandom()));
      return longint'(int'($urandom_range(0, 3000))) - 1500;
   endfunction

   // Presents one cycle of inputs; a sample is accepted only when 4 cycles have passed since the last one.
   task automatic cycle(input bit v, input longint e, input bit h, input bit c);
      longint u;
      bit     s;
      i_valid = v;
      i_err   = DATA_W'(e);
      i_hold  = h;
      i_clear = c;
      if (c && cyc >= free_cyc) begin
         m_acc = 0;
         m_aw  = 0;
      end
      if (v && cyc >= free_cyc) begin
         model(e, h, u, s);
         sb.push_back('{u, s, cyc + 3});
         free_cyc = cyc + 4;
      end
      @(posedge i_CLK);
      #1;
   endtask

   task automatic send(input longint e, input bit h, input bit spam);
      cycle(1'b1, e, h, 1'b0);
      repeat (3) cycle(spam, rnd_err(), h, 1'b0);
   endtask

   always @(negedge i_CLK) begin : monitor
      exp_t x;
      if (o_valid) begin
         n_vld++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_valid: o_PI=%0d with no sample pending", o_PI);
         end else begin
            x = sb.pop_front();
            check("o_PI", o_PI, x.u);
            check("o_sat", o_sat, x.sat);
            check("latency_cycle", cyc, x.cyc);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin : stim
      int base;
      repeat (3) @(posedge i_CLK);
      #1;
      i_RST = 1'b0;

      repeat (10) cycle(1'b0, 0, 1'b0, 1'b0);
      check("rst_o_PI", o_PI, 0);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_busy", o_busy, 0);
      check("rst_o_sat", o_sat, 0);

      send(10, 1'b0, 1'b0);
      check("t2_first", o_PI, 20);
      send(10, 1'b0, 1'b0);
      check("t2_second", o_PI, 30);

      cycle(1'b0, 0, 1'b0, 1'b1);
      send(600, 1'b0, 1'b0);
      check("t3_sat_out", o_PI, 1000);
      check("t3_sat_flag", o_sat, 1);
      send(600, 1'b0, 1'b0);
      check("t3_sat_out2", o_PI, 1000);
      send(-600, 1'b0, 1'b0);
      check("t3_unwind_out", o_PI, -800);
      check("t3_unwind_flag", o_sat, 0);

      base = n_vld;
      for (int i = 0; i < 8; i++) begin
         check("t4_busy", o_busy, longint'((i % 4) != 0));
         cycle(1'b1, longint'(int'($urandom_range(0, 200))) - 100, 1'b0, 1'b0);
      end
      repeat (4) cycle(1'b0, 0, 1'b0, 1'b0);
      check("t4_valid_count", n_vld - base, 2);

      cycle(1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         send(10, 1'b1, 1'b0);
         check("t5_hold_out", o_PI, 10);
      end
      send(25, 1'b0, 1'b0);
      send(25, 1'b0, 1'b0);
      check("t5_acc50_out", o_PI, 75);
      cycle(1'b0, 0, 1'b1, 1'b1);
      send(5, 1'b0, 1'b0);
      check("t5_after_clear", o_PI, 10);

      cycle(1'b1, 10, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b0, 1'b0);
      i_RST = 1'b1;
      sb.delete();
      m_acc = 0;
      m_aw  = 0;
      free_cyc = 0;
      @(posedge i_CLK);
      #1;
      check("t6_o_PI", o_PI, 0);
      check("t6_o_valid", o_valid, 0);
      check("t6_o_busy", o_busy, 0);
      check("t6_o_sat", o_sat, 0);
      i_RST = 1'b0;
      repeat (3) cycle(1'b0, 0, 1'b0, 1'b0);
      send(10, 1'b0, 1'b0);
      check("t6_restart", o_PI, 20);

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 7) == 0) cycle(1'b0, 0, 1'b0, 1'b1);
         repeat ($urandom_range(0, 2)) cycle(1'b0, 0, 1'b0, 1'b0);
         send(rnd_err(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      end

      repeat (8) cycle(1'b0, 0, 1'b0, 1'b0);
      check("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
